regfile_2r1w: RTL and testbench
===============================

REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter XLEN, default 32, data width of registers, write data, read data and immediate.
REQ-002 Parameter NREGS, default 32, register count; address width is log2(NREGS) = 5.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 i_raddr_a  input  5  read port A address.
REQ-006 i_raddr_b  input  5  read port B address.
REQ-007 i_wen  input  1  write enable.
REQ-008 i_waddr  input  5  write address.
REQ-009 i_wdata  input  XLEN  write data.
REQ-010 o_rdata_a  output  XLEN  read port A data.
REQ-011 o_rdata_b  output  XLEN  read port B data.
REQ-012 instr_i  input  32  raw instruction word for immediate extraction.
REQ-013 format_i  input  3  instruction format code, type core::format_t.
REQ-014 imm_o  output  XLEN  decoded immediate.

Function
REQ-015 Register x0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-016 On a rising clk edge with i_wen=1 and i_waddr!=0, register[i_waddr] SHALL take i_wdata; with i_wen=0 no register changes.
REQ-017 Read ports SHALL be combinational (zero latency): o_rdata_x = register[i_raddr_x].
REQ-018 Write-through bypass: when i_wen=1, i_waddr!=0 and i_waddr==i_raddr_x, o_rdata_x SHALL equal i_wdata in the same cycle.
REQ-019 Both read ports SHALL be independent; same address on both ports returns identical data.
REQ-020 imm_o SHALL be purely combinational from instr_i and format_i.
REQ-021 Format encoding: NOP=0, R=1, I=2, S=3, B=4, U=5, J=6, 7 reserved.
REQ-022 I: imm_o = sign-extend(instr[31:20]).
REQ-023 S: imm_o = sign-extend({instr[31:25], instr[11:7]}).
REQ-024 B: imm_o = sign-extend({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
REQ-025 U: imm_o = {instr[31:12], 12'b0}.
REQ-026 J: imm_o = sign-extend({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
REQ-027 NOP, R and reserved code 7: imm_o = 0.
REQ-028 Sign bit for every sign-extended format SHALL be instr[31].

Reset
REQ-029 rst=0 SHALL asynchronously clear all registers to 0, independent of clk.
REQ-030 While rst=0, writes SHALL be ignored; read ports return 0 (bypass disabled).
REQ-031 Immediate path SHALL be unaffected by reset.
REQ-032 Deassertion of rst mid-cycle SHALL NOT cause a write before the next rising clk edge.

Structure
REQ-033 format_t enum (3 bits, codes per REQ-021) and XLEN SHALL reside in shared package core.
REQ-034 Immediate extraction SHALL be a separate sub-module imm_generator (ports instr_i, format_i, imm_o) instantiated inside regfile_2r1w.
REQ-035 Register storage SHALL be NREGS-1 flops (x0 not stored).

Verification
REQ-036 Reset: drive rst=0, then read all 32 addresses -> every o_rdata = 0.
REQ-037 Write x5=0xDEADBEEF, next cycle raddr_a=5, raddr_b=5 -> both ports 0xDEADBEEF; write x0=0x12345678 -> x0 reads 0.
REQ-038 Bypass: i_wen=1, i_waddr=7, i_wdata=0xA5A5A5A5, i_raddr_a=7 same cycle -> o_rdata_a=0xA5A5A5A5; raddr_b=8 unaffected.
REQ-039 Immediates: instr 0xFFF00093 (addi x1,x0,-1), I -> 0xFFFFFFFF; 0x00112423 (sw x1,8(x2)), S -> 0x00000008; 0x123450B7, U -> 0x12345000.
REQ-040 Branch/jump: 0xFE000EE3 (beq x0,x0,-4), B -> 0xFFFFFFFC; 0x008000EF (jal x1,8), J -> 0x00000008; same words with format R or 7 -> 0.
REQ-041 Async reset mid-operation: after writes, pulse rst=0 between clock edges -> all reads 0 immediately, no clock needed.

Source files
------------

// File: rtl/regfile_2r1w_pkg.sv
// Shared core definitions: default datapath width and the instruction format codes
// used by the immediate decoder.
package core;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    FMT_NOP  = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6,
    FMT_RSVD = 3'd7
  } format_t;
endpackage

// File: rtl/regfile_2r1w_if.sv
// Register-file access bus: two read ports and one write port.
// The master drives addresses and write data; the slave returns read data.
interface regfile_2r1w_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   i_raddr_a;
  logic [AW-1:0]   i_raddr_b;
  logic            i_wen;
  logic [AW-1:0]   i_waddr;
  logic [XLEN-1:0] i_wdata;
  logic [XLEN-1:0] o_rdata_a;
  logic [XLEN-1:0] o_rdata_b;

  modport master (
    output i_raddr_a, i_raddr_b, i_wen, i_waddr, i_wdata,
    input  o_rdata_a, o_rdata_b
  );

  modport slave (
    input  i_raddr_a, i_raddr_b, i_wen, i_waddr, i_wdata,
    output o_rdata_a, o_rdata_b
  );
endinterface

// File: rtl/regfile_2r1w_imm_generator.sv
// Combinational RISC-V style immediate extraction; every sign-extended format
// takes its sign from instr_i[31].
module imm_generator
  import core::*;
#(
  parameter int XLEN = core::XLEN
) (
  input  logic [31:0]     instr_i,
  input  format_t         format_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (format_i)
      FMT_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U:   imm32 = {instr_i[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Wider datapaths keep extending the 32-bit immediate's sign.
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read / one-write integer register file with hardwired-zero x0, same-cycle
// write-through bypass on both read ports, and an embedded immediate decoder.
module regfile_2r1w
  import core::*;
#(
  parameter int XLEN  = core::XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  regfile_2r1w_if.slave   rf,
  input  logic [31:0]     instr_i,
  input  format_t         format_i,
  output logic [XLEN-1:0] imm_o
);

  localparam int AW = $clog2(NREGS);

  // x0 has no storage; index 0 is never materialised.
  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] regs_d [1:NREGS-1];
  logic [XLEN-1:0] rdata  [2];
  logic            wr_en;

  assign wr_en = rf.i_wen && (rf.i_waddr != '0);

  always_comb begin
    for (int r = 1; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
      if (wr_en && (rf.i_waddr == AW'(r))) begin
        regs_d[r] = rf.i_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 1; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Reads are combinational; the bypass is suppressed while reset is held.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      logic [AW-1:0] addr;
      addr     = (p == 0) ? rf.i_raddr_a : rf.i_raddr_b;
      rdata[p] = '0;
      for (int r = 1; r < NREGS; r++) begin
        if (addr == AW'(r)) begin
          rdata[p] = regs_q[r];
        end
      end
      if (!rst) begin
        rdata[p] = '0;
      end else if (wr_en && (rf.i_waddr == addr)) begin
        rdata[p] = rf.i_wdata;
      end
    end
  end

  assign rf.o_rdata_a = rdata[0];
  assign rf.o_rdata_b = rdata[1];

  imm_generator #(
    .XLEN(XLEN)
  ) u_imm_generator (
    .instr_i  (instr_i),
    .format_i (format_i),
    .imm_o    (imm_o)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: reset sweep, writes, bypass, random traffic against a
// reference array, async reset pulse, and a table of immediate decodes.
module tb_regfile_2r1w;
  import core::*;

  typedef struct {
    string       name;
    logic [31:0] instr;
    format_t     fmt;
    logic [31:0] exp;
  } imm_vec_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_i = '0;
  format_t     format_i = FMT_NOP;
  logic [31:0] imm_o;

  regfile_2r1w_if #(.XLEN(32), .AW(5)) rf ();

  regfile_2r1w #(
    .XLEN  (32),
    .NREGS (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rf       (rf),
    .instr_i  (instr_i),
    .format_i (format_i),
    .imm_o    (imm_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  sb_t         sb_q[$];
  logic [31:0] model [32];
  imm_vec_t    vecs [13];

  task automatic push(input string name, input int sel, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t         e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       act = rf.o_rdata_a;
        1:       act = rf.o_rdata_b;
        default: act = imm_o;
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
      end else begin
        $display("ok   %s = %08h", e.name, act);
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!rst || a == 5'd0) return '0;
    if (rf.i_wen && rf.i_waddr == a) return rf.i_wdata;
    return model[a];
  endfunction

  task automatic chk_rd(input string name, input logic [4:0] a, input logic [4:0] b,
                        input logic [31:0] ea, input logic [31:0] eb);
    rf.i_raddr_a = a;
    rf.i_raddr_b = b;
    #1;
    push({name, "_a"}, 0, ea);
    push({name, "_b"}, 1, eb);
    drain();
  endtask

  task automatic model_rd(input string name, input logic [4:0] a, input logic [4:0] b);
    rf.i_raddr_a = a;
    rf.i_raddr_b = b;
    #1;
    push({name, "_a"}, 0, exp_rd(a));
    push({name, "_b"}, 1, exp_rd(b));
    drain();
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rf.i_wen   = 1'b1;
    rf.i_waddr = a;
    rf.i_wdata = d;
    @(posedge clk);
    if (a != 5'd0) model[a] = d;
    #1 rf.i_wen = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"imm_i_addi_m1",  32'hFFF00093, FMT_I,    32'hFFFFFFFF};
    vecs[1]  = '{"imm_s_sw_8",     32'h00112423, FMT_S,    32'h00000008};
    vecs[2]  = '{"imm_u_lui",      32'h123450B7, FMT_U,    32'h12345000};
    vecs[3]  = '{"imm_b_beq_m4",   32'hFE000EE3, FMT_B,    32'hFFFFFFFC};
    vecs[4]  = '{"imm_j_jal_8",    32'h008000EF, FMT_J,    32'h00000008};
    vecs[5]  = '{"imm_r_beqword",  32'hFE000EE3, FMT_R,    32'h00000000};
    vecs[6]  = '{"imm_7_beqword",  32'hFE000EE3, FMT_RSVD, 32'h00000000};
    vecs[7]  = '{"imm_r_jalword",  32'h008000EF, FMT_R,    32'h00000000};
    vecs[8]  = '{"imm_7_jalword",  32'h008000EF, FMT_RSVD, 32'h00000000};
    vecs[9]  = '{"imm_nop",        32'hFFF00093, FMT_NOP,  32'h00000000};
    vecs[10] = '{"imm_i_addi_10",  32'h00A00093, FMT_I,    32'h0000000A};
    vecs[11] = '{"imm_s_sw_m4",    32'hFE112E23, FMT_S,    32'hFFFFFFFC};
    vecs[12] = '{"imm_u_neg",      32'hFFFFF0B7, FMT_U,    32'hFFFFF000};

    rf.i_raddr_a = '0;
    rf.i_raddr_b = '0;
    rf.i_wen     = 1'b0;
    rf.i_waddr   = '0;
    rf.i_wdata   = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset held: every address reads 0 even with a write aimed at it.
    #3 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rf.i_wen   = 1'b1;
      rf.i_waddr = 5'(i);
      rf.i_wdata = 32'hFFFFFFFF;
      chk_rd($sformatf("rst_x%0d", i), 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end
    instr_i  = 32'hFFF00093;
    format_i = FMT_I;
    #1 push("imm_in_reset", 2, 32'hFFFFFFFF);
    drain();

    // Mid-cycle release must not commit anything before the next edge.
    @(negedge clk);
    rf.i_wen = 1'b0;
    #2 rst = 1'b1;
    chk_rd("post_rst_x9", 5'd9, 5'd31, 32'h0, 32'h0);

    write_reg(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk_rd("x5_both", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    write_reg(5'd0, 32'h12345678);
    @(negedge clk);
    chk_rd("x0_write", 5'd0, 5'd0, 32'h0, 32'h0);

    @(negedge clk);
    rf.i_wen   = 1'b0;
    rf.i_waddr = 5'd5;
    rf.i_wdata = 32'h0;
    @(posedge clk);
    #1 chk_rd("wen0_hold", 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);

    write_reg(5'd8, 32'h0BADF00D);
    @(negedge clk);
    rf.i_wen   = 1'b1;
    rf.i_waddr = 5'd7;
    rf.i_wdata = 32'hA5A5A5A5;
    chk_rd("bypass_x7", 5'd7, 5'd8, 32'hA5A5A5A5, 32'h0BADF00D);
    @(posedge clk);
    model[7] = 32'hA5A5A5A5;
    #1 rf.i_wen = 1'b0;
    chk_rd("x7_after", 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5);

    @(negedge clk);
    rf.i_wen   = 1'b1;
    rf.i_waddr = 5'd0;
    rf.i_wdata = 32'hFFFFFFFF;
    chk_rd("bypass_x0", 5'd0, 5'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1 rf.i_wen = 1'b0;

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rf.i_wen   = 1'($urandom_range(0, 1));
      rf.i_waddr = 5'($urandom_range(0, 31));
      rf.i_wdata = $urandom;
      model_rd($sformatf("rnd%0d", i), 5'($urandom_range(0, 31)),
               (i % 4 == 0) ? rf.i_waddr : 5'($urandom_range(0, 31)));
      @(posedge clk);
      if (rf.i_wen && rf.i_waddr != 5'd0) model[rf.i_waddr] = rf.i_wdata;
    end
    #1 rf.i_wen = 1'b0;

    for (int i = 0; i < 13; i++) begin
      instr_i  = vecs[i].instr;
      format_i = vecs[i].fmt;
      #1 push(vecs[i].name, 2, vecs[i].exp);
      drain();
    end

    // Async reset pulse between edges: reads clear with no clock involved.
    write_reg(5'd5, 32'hDEADBEEF);
    write_reg(5'd7, 32'hA5A5A5A5);
    @(negedge clk);
    chk_rd("pre_pulse", 5'd5, 5'd7, 32'hDEADBEEF, 32'hA5A5A5A5);
    rst      = 1'b0;
    instr_i  = 32'h123450B7;
    format_i = FMT_U;
    #1;
    push("pulse_x5", 0, 32'h0);
    push("pulse_x7", 1, 32'h0);
    push("pulse_imm", 2, 32'h12345000);
    drain();
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    chk_rd("after_pulse", 5'd5, 5'd7, 32'h0, 32'h0);

    write_reg(5'd3, 32'h13572468);
    @(negedge clk);
    model_rd("x3_after_rst", 5'd3, 5'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
